sort_result_checker: RTL

- Self-checking consumer for the five array-element result ports of `RISC_V_Processor` (`ele1`..`ele5`).
- Waits until the five values hold steady for a programmable number of cycles, then checks one adjacent pair per cycle for ascending order.
- Reports sticky done/pass/fail status, the first failing pair, and a timeout.
- Sits directly downstream of the processor inside the top-level bench/FPGA wrapper.

---
 rtl/sort_result_checker_if.sv | 26 ++
 rtl/sort_result_checker.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sort_result_checker_if.sv
// Result bundle between the processor's array-element outputs and the
// sort result checker: five elements in, sticky verdict out.
interface sort_result_checker_if #(
  parameter int W = 64
);
  logic [W-1:0] ele1;
  logic [W-1:0] ele2;
  logic [W-1:0] ele3;
  logic [W-1:0] ele4;
  logic [W-1:0] ele5;
  logic         done;
  logic         pass;
  logic         timeout;
  logic [2:0]   fail_idx;
  logic [31:0]  cycles;

  modport master (
    output ele1, ele2, ele3, ele4, ele5,
    input  done, pass, timeout, fail_idx, cycles
  );

  modport slave (
    input  ele1, ele2, ele3, ele4, ele5,
    output done, pass, timeout, fail_idx, cycles
  );
endinterface

// File: rtl/sort_result_checker.sv
// Waits for five result elements to settle, then checks ascending order.
// Define SORT_CHECK_SIGNED_EN for two's-complement element comparison.
module sort_result_checker #(
  parameter int W             = 64,
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT       = 100000
) (
  input logic                  clk,
  input logic                  reset,
  sort_result_checker_if.slave bus
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    WATCH = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [4:0][W-1:0] in_w;
  logic [4:0][W-1:0] snap_q, snap_d;
  logic [SW-1:0]     stable_q, stable_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       cyc_q, cyc_d, cyc_inc;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              tmo_q, tmo_d;
  logic [2:0]        fidx_q, fidx_d;
  logic [31:0]       cycles_q, cycles_d;

  logic              eq;
  logic              stable_hit;
  logic              wait_hit;
  logic              gt;
  logic [W-1:0]      lhs, rhs;

  assign in_w = {bus.ele5, bus.ele4, bus.ele3, bus.ele2, bus.ele1};

  assign eq         = (in_w == snap_q);
  assign stable_hit = eq && (stable_q == SW'(STABLE_CYCLES - 1));
  assign wait_hit   = (wait_q == TW'(TIMEOUT - 1));
  assign cyc_inc    = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;

  assign lhs = snap_q[idx_q];
  assign rhs = snap_q[{1'b0, idx_q} + 3'd1];

`ifdef SORT_CHECK_SIGNED_EN
  assign gt = $signed(lhs) > $signed(rhs);
`else
  assign gt = lhs > rhs;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WATCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WATCH: begin
        if (stable_hit)    state_d = CHECK;
        else if (wait_hit) state_d = DONE;
      end
      CHECK: begin
        if (gt || idx_q == 2'd3) state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = WATCH;
    endcase
  end

  always_comb begin
    snap_d   = snap_q;
    stable_d = stable_q;
    wait_d   = wait_q;
    idx_d    = idx_q;
    cyc_d    = cyc_q;
    done_d   = done_q;
    pass_d   = pass_q;
    tmo_d    = tmo_q;
    fidx_d   = fidx_q;
    cycles_d = cycles_q;
    case (state_q)
      WATCH: begin
        cyc_d  = cyc_inc;
        wait_d = wait_q + TW'(1);
        if (eq) begin
          stable_d = stable_q + SW'(1);
        end else begin
          snap_d   = in_w;
          stable_d = '0;
        end
        // a settled window wins over a simultaneous timeout
        if (stable_hit) begin
          idx_d = 2'd0;
        end else if (wait_hit) begin
          done_d   = 1'b1;
          tmo_d    = 1'b1;
          pass_d   = 1'b0;
          fidx_d   = 3'd0;
          cycles_d = cyc_inc;
        end
      end
      CHECK: begin
        cyc_d = cyc_inc;
        if (gt) begin
          done_d   = 1'b1;
          pass_d   = 1'b0;
          fidx_d   = {1'b0, idx_q} + 3'd1;
          cycles_d = cyc_inc;
        end else if (idx_q == 2'd3) begin
          done_d   = 1'b1;
          pass_d   = 1'b1;
          fidx_d   = 3'd0;
          cycles_d = cyc_inc;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q   <= '0;
      stable_q <= '0;
      wait_q   <= '0;
      idx_q    <= '0;
      cyc_q    <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
      fidx_q   <= '0;
      cycles_q <= '0;
    end else begin
      snap_q   <= snap_d;
      stable_q <= stable_d;
      wait_q   <= wait_d;
      idx_q    <= idx_d;
      cyc_q    <= cyc_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      tmo_q    <= tmo_d;
      fidx_q   <= fidx_d;
      cycles_q <= cycles_d;
    end
  end

  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.timeout  = tmo_q;
  assign bus.fail_idx = fidx_q;
  assign bus.cycles   = cycles_q;

endmodule
